// File: rtl/logpwr_vec_avg.sv
// logpwr_vec_avg: per-bin vector averager for log-power frames.
//
// Each bin lives in a block RAM and is updated with a first-order IIR
//   y <- y + ((x - y) >>> shift)
// and the averaged frame is streamed out with a corrected tlast.
//
// Optional feature: define LOGPWR_VEC_AVG_PEAK_HOLD_EN to build the peak-hold
// path (y <- max(y, x) when cfg_peak_hold=1). Without it cfg_peak_hold is
// ignored and no comparator is built.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear           pulse; next frame start becomes a load (pass-through) frame
//   cfg_len         frame length in bins, 1..2**MAX_LEN_LOG2 (sampled at bin 0)
//   cfg_shift       IIR shift 0..15 (sampled at bin 0)
//   cfg_peak_hold   peak-hold select (sampled at bin 0, macro builds only)
//   i_t*            AXI-Stream input of signed log-power samples
//   o_t*            AXI-Stream output of averaged samples
//   err_len         one-cycle pulse when i_tlast and the bin counter disagree
module logpwr_vec_avg #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned MAX_LEN_LOG2 = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [MAX_LEN_LOG2:0]   cfg_len,
  input  logic [3:0]              cfg_shift,
  input  logic                    cfg_peak_hold,
  input  logic [DATA_W-1:0]       i_tdata,
  input  logic                    i_tlast,
  input  logic                    i_tvalid,
  output logic                    i_tready,
  output logic [DATA_W-1:0]       o_tdata,
  output logic                    o_tlast,
  output logic                    o_tvalid,
  input  logic                    o_tready,
  output logic                    err_len
);

  localparam int unsigned Depth = 2 ** MAX_LEN_LOG2;
  localparam int unsigned AW    = MAX_LEN_LOG2;
  localparam int unsigned LW    = MAX_LEN_LOG2 + 1;

  // ---------------------------------------------------------------------------
  // Handshake / single advance enable
  // ---------------------------------------------------------------------------
  logic en;
  logic hs;

  assign en       = !o_tvalid || o_tready;
  assign i_tready = en && !rst;
  assign hs       = i_tvalid && i_tready;

  // ---------------------------------------------------------------------------
  // Frame tracking and configuration capture
  // ---------------------------------------------------------------------------
  logic [AW-1:0] bin_q;
  logic [LW-1:0] len_q;
  logic [3:0]    shift_q;
  logic          first_q;
  logic          pend_q;

  logic          frame_start;
  logic [LW-1:0] len_cur;
  logic [3:0]    shift_cur;
  logic          wrap;
  logic          frame_end;
  logic          len_err;

  assign frame_start = (bin_q == '0);
  // Configuration is taken live at bin 0 and held for the rest of the frame.
  assign len_cur     = frame_start ? cfg_len : len_q;
  assign shift_cur   = frame_start ? cfg_shift : shift_q;
  assign wrap        = ({1'b0, bin_q} == (len_cur - LW'(1)));
  assign frame_end   = wrap || i_tlast;
  assign len_err     = wrap ^ i_tlast;

`ifdef LOGPWR_VEC_AVG_PEAK_HOLD_EN
  logic peak_q;
  logic peak_cur;
  assign peak_cur = frame_start ? cfg_peak_hold : peak_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q <= 1'b0;
    end else if (hs && frame_start) begin
      peak_q <= cfg_peak_hold;
    end
  end
`else
  logic unused_peak_hold;
  assign unused_peak_hold = cfg_peak_hold;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q   <= '0;
      len_q   <= '0;
      shift_q <= '0;
      first_q <= 1'b1;
      pend_q  <= 1'b0;
      err_len <= 1'b0;
    end else begin
      err_len <= hs && len_err;
      if (hs) begin
        if (frame_start) begin
          len_q   <= cfg_len;
          shift_q <= cfg_shift;
        end
        bin_q <= frame_end ? '0 : bin_q + AW'(1);
      end
      // A clear between frames takes effect at once; inside a frame it waits
      // for the frame end. A clear on the frame-end handshake counts too.
      if (hs && frame_end) begin
        first_q <= pend_q || clear;
        pend_q  <= 1'b0;
      end else if (clear) begin
        if (frame_start && !hs) begin
          first_q <= 1'b1;
        end else begin
          pend_q <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 (cycle H+1): sample registers, RAM read data, update computation
  // ---------------------------------------------------------------------------
  logic              s1_valid;
  logic [AW-1:0]     s1_bin;
  logic [DATA_W-1:0] s1_x;
  logic              s1_last;
  logic              s1_first;
  logic [3:0]        s1_shift;
  logic              s1_fwd;
  logic [DATA_W-1:0] s1_fwd_y;

  logic [DATA_W-1:0] ram [Depth];
  logic [DATA_W-1:0] ram_rd;

  logic                     wr_en;
  logic [DATA_W-1:0]        wr_data;
  logic [DATA_W-1:0]        y_old;
  logic signed [DATA_W:0]   diff;
  logic signed [DATA_W:0]   diff_sh;
  logic signed [DATA_W+1:0] sum;
  logic [DATA_W-1:0]        iir_y;

  assign wr_en = en && s1_valid && !rst;

`ifdef LOGPWR_VEC_AVG_PEAK_HOLD_EN
  logic              s1_peak;
  logic [DATA_W-1:0] peak_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_peak <= 1'b0;
    end else if (en && hs) begin
      s1_peak <= peak_cur;
    end
  end

  assign peak_y = ($signed(s1_x) > $signed(y_old)) ? s1_x : y_old;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_bin   <= '0;
      s1_x     <= '0;
      s1_last  <= 1'b0;
      s1_first <= 1'b0;
      s1_shift <= '0;
      s1_fwd   <= 1'b0;
      s1_fwd_y <= '0;
    end else if (en) begin
      s1_valid <= hs;
      if (hs) begin
        s1_bin   <= bin_q;
        s1_x     <= i_tdata;
        s1_last  <= frame_end;
        s1_first <= first_q;
        s1_shift <= shift_cur;
        // The RAM read this cycle returns the pre-write value when the bin
        // being written now is the one being read (cfg_len=1), so keep the
        // fresh result alongside.
        s1_fwd   <= wr_en && (s1_bin == bin_q);
        s1_fwd_y <= wr_data;
      end
    end
  end

  // Read-before-write within a cycle; the forwarding flag covers the overlap.
  always_ff @(posedge clk) begin
    if (en) begin
      ram_rd <= ram[bin_q];
    end
    if (wr_en) begin
      ram[s1_bin] <= wr_data;
    end
  end

  always_comb begin
    y_old   = s1_fwd ? s1_fwd_y : ram_rd;
    diff    = $signed({s1_x[DATA_W-1], s1_x}) - $signed({y_old[DATA_W-1], y_old});
    diff_sh = diff >>> s1_shift;
    sum     = $signed({{2{y_old[DATA_W-1]}}, y_old}) + $signed({diff_sh[DATA_W], diff_sh});
    if ((sum[DATA_W+1] != sum[DATA_W]) || (sum[DATA_W] != sum[DATA_W-1])) begin
      iir_y = sum[DATA_W+1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      iir_y = sum[DATA_W-1:0];
    end

    wr_data = iir_y;
`ifdef LOGPWR_VEC_AVG_PEAK_HOLD_EN
    if (s1_peak) begin
      wr_data = peak_y;
    end
`endif
    if (s1_first) begin
      wr_data = s1_x;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 (cycle H+2): output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      o_tvalid <= 1'b0;
      o_tdata  <= '0;
      o_tlast  <= 1'b0;
    end else if (en) begin
      o_tvalid <= s1_valid;
      if (s1_valid) begin
        o_tdata <= wr_data;
        o_tlast <= s1_last;
      end
    end
  end

endmodule
